// File: rtl/aes_pkg.sv
// Shared types and byte-shuffling helpers for the column-serial AES round back-end.
// State byte 0 is [127:120]; column c occupies [127-32c -: 32], row 0 first.
package aes_pkg;

  localparam int AES_NUM_COLS = 4;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [1:0]   col_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  function automatic col_t get_col(state_t s, col_idx_t c);
    return s[127 - 32*int'(c) -: 32];
  endfunction

  // Output byte (row r, col c) takes input byte (row r, col (c+r) mod 4).
  function automatic state_t shift_rows(state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < AES_NUM_COLS; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % AES_NUM_COLS) + row) -: 8];
      end
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// MixColumns for one 32-bit column, purely combinational.
// Row 0 is col_in[31:24]; matrix rows are [2 3 1 1] rotated right per row.
module aes_mix_columns
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign col_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_mix_round_stage.sv
// Column-serial AES round back-end: ShiftRows on capture, then one column per
// cycle through a shared MixColumns unit (bypassed on the final round) and AddRoundKey.
module aes_mix_round_stage
  import aes_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  fsm_t     state_q, state_d;
  col_idx_t col_idx_q;
  state_t   work_q, key_q, result_q;
  logic     last_q;

  col_t mix_in, mix_out, res_col;
  logic accept, last_col;

  assign mix_in   = get_col(work_q, col_idx_q);
  assign res_col  = (last_q ? mix_in : mix_out) ^ get_col(key_q, col_idx_q);
  assign last_col = (col_idx_q == col_idx_t'(NUM_COLS - 1));

  aes_mix_columns u_mix_columns (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_col) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the data registers are plain flops, not a memory, so clearing them on reset is cheap and keeps state_out at 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx_q <= '0;
      work_q    <= '0;
      key_q     <= '0;
      result_q  <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values, independent of statement order.
      work_q    <= shift_rows(state_in);
      key_q     <= key_in;
      last_q    <= last_round;
      col_idx_q <= '0;
    end else if (state_q == RUN) begin
      result_q[127 - 32*int'(col_idx_q) -: 32] <= res_col;
      col_idx_q <= col_idx_q + 2'd1;
    end
  end

  assign state_out = result_q;

endmodule

// File: tb/tb_aes_mix_round_stage.sv
// Self-checking bench: directed steps, scoreboard queue of expected states fed
// by an independent byte-level AES model.
module tb_aes_mix_round_stage;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  state_t state_in = '0;
  state_t key_in = '0;
  logic   last_round = 1'b0;
  logic   out_valid;
  logic   out_ready = 1'b0;
  state_t state_out;

  state_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  localparam state_t R1_STATE = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam state_t R1_KEY   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam state_t R1_OUT   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam state_t SR_OUT   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  aes_mix_round_stage #(.NUM_COLS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .key_in     (key_in),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic state_t model(state_t st, state_t key, logic last);
    logic [7:0] b[16];
    logic [7:0] s[16];
    logic [7:0] m[16];
    state_t     o;
    for (int i = 0; i < 16; i++) b[i] = st[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4*c + r] = b[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[4*c + r] = gmul(s[4*c + r], 8'h02) ^ gmul(s[4*c + (r+1)%4], 8'h03)
                   ^ s[4*c + (r+2)%4] ^ s[4*c + (r+3)%4];
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = (last ? s[i] : m[i]) ^ key[127 - 8*i -: 8];
    return o;
  endfunction

  task automatic check(input string tag, input state_t obs, input state_t exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input state_t st, input state_t k, input logic lr, input state_t exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", state_t'(in_ready), 128'd1);
    state_in   = st;
    key_in     = k;
    last_round = lr;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp);
    check("accept_busy", state_t'(in_ready), 128'd0);
  endtask

  task automatic recv(input string tag);
    int     n;
    state_t e;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, state_t'(n), 128'd4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, state_out, e);
    tick();
    check({tag, "_valid_drop"}, state_t'(out_valid), 128'd0);
    check({tag, "_ready_back"}, state_t'(in_ready), 128'd1);
  endtask

  initial begin
    state_t st;
    state_t k;
    state_t e;
    logic   lr;
    int     acc_cyc[$];
    int     got;

    // Reset state
    #12;
    check("rst_in_ready", state_t'(in_ready), 128'd1);
    check("rst_out_valid", state_t'(out_valid), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 round 1
    send(R1_STATE, R1_KEY, 1'b0, R1_OUT);
    recv("round1");

    // Final-round bypass: pure ShiftRows
    send(R1_STATE, '0, 1'b1, SR_OUT);
    recv("bypass");

    // Single MixColumns column
    st = 128'hdb000000_00130000_00005300_00000045;
    send(st, '0, 1'b0, model(st, '0, 1'b0));
    recv("mixcol");
    check("mixcol_col0", {96'd0, state_out[127:96]}, 128'h8e4da1bc);

    // Backpressure with a competing in_valid during the hold
    out_ready = 1'b0;
    send(R1_STATE, R1_KEY, 1'b0, R1_OUT);
    e = exp_q.pop_front();
    repeat (4) tick();
    check("bp_valid_rise", state_t'(out_valid), 128'd1);
    in_valid = 1'b1;
    state_in = 128'h0123456789abcdef0123456789abcdef;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", state_t'(out_valid), 128'd1);
      check("bp_data_hold", state_out, e);
      check("bp_in_ready", state_t'(in_ready), 128'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_release_data", state_out, e);
    tick();
    check("bp_idle_ready", state_t'(in_ready), 128'd1);
    check("bp_idle_valid", state_t'(out_valid), 128'd0);
    check("bp_out_holds", state_out, e);
    repeat (6) tick();
    check("bp_no_extra", state_t'(out_valid), 128'd0);

    // Back-to-back with in_valid held high
    st = 128'h00112233445566778899aabbccddeeff;
    k  = 128'h0f0e0d0c0b0a09080706050403020100;
    out_ready  = 1'b1;
    state_in   = R1_STATE;
    key_in     = R1_KEY;
    last_round = 1'b0;
    in_valid   = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(acc_cyc.size() == 1 ? R1_OUT : model(st, k, 1'b0));
      end
      if (out_valid && out_ready) begin
        check("b2b_q_nonempty", state_t'(exp_q.size() > 0), 128'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("b2b_data", state_out, e);
        got++;
      end
      tick();
      if (acc_cyc.size() == 1) begin
        state_in = st;
        key_in   = k;
      end else if (acc_cyc.size() >= 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_outputs", state_t'(got), 128'd2);
    check("b2b_accepts", state_t'(acc_cyc.size()), 128'd2);
    check("b2b_spacing", state_t'(acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] : 0), 128'd6);
    exp_q.delete();
    tick();

    // Asynchronous reset at col_idx = 2
    send(R1_STATE, R1_KEY, 1'b0, R1_OUT);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", state_t'(out_valid), 128'd0);
    check("arst_in_ready", state_t'(in_ready), 128'd1);
    check("arst_state_out", state_out, 128'd0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    tick();
    send(R1_STATE, R1_KEY, 1'b0, R1_OUT);
    recv("post_reset");

    // Random states against the model
    for (int i = 0; i < 4; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      lr = 1'($urandom_range(0, 1));
      send(st, k, lr, model(st, k, lr));
      recv("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
